// File: rtl/multi_player_move_ctl.sv
`default_nettype none
// ============================================================================
// Module      : multi_player_move_ctl
// Description : Frame-synchronous movement controller for NUM_PLAYERS
//               characters sharing one mouse/button input. The selected
//               player moves horizontally (screen limits, gate obstacle);
//               every player owns an independent vertical jump FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_player_move_ctl #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 12,
  parameter int X_START     = 0,
  parameter int X_MAX       = 660,
  parameter int GATE_MIN    = 310,
  parameter int GATE_MAX    = 450,
  parameter int STEP        = 1,
  parameter int Y_GROUND    = 500,
  parameter int JUMP_HEIGHT = 64,
  parameter int JUMP_STEP   = 4,
  localparam int SEL_W      = $clog2(NUM_PLAYERS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_v_tick,
  input  logic                         i_m_left,
  input  logic                         i_m_right,
  input  logic                         i_m_jump,
  input  logic [SEL_W-1:0]             i_sel,
  input  logic                         i_gate_open,
  output logic [NUM_PLAYERS*POS_W-1:0] o_xpos,
  output logic [NUM_PLAYERS*POS_W-1:0] o_ypos,
  output logic [NUM_PLAYERS-1:0]       o_jumping
);

  localparam logic [POS_W-1:0] c_x_start  = POS_W'(X_START);
  localparam logic [POS_W-1:0] c_x_max    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] c_gate_min = POS_W'(GATE_MIN);
  localparam logic [POS_W-1:0] c_gate_max = POS_W'(GATE_MAX);
  localparam logic [POS_W-1:0] c_step     = POS_W'(STEP);
  localparam logic [POS_W-1:0] c_y_ground = POS_W'(Y_GROUND);
  localparam logic [POS_W-1:0] c_jh       = POS_W'(JUMP_HEIGHT);
  localparam logic [POS_W-1:0] c_jstep    = POS_W'(JUMP_STEP);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } jump_state_t;

  logic r_v_tick_q;
  logic w_frame;

  // Delayed copy of v_tick for rising-edge (frame) detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_v_tick_q <= 1'b0;
    else        r_v_tick_q <= i_v_tick;
  end

  assign w_frame = i_v_tick && !r_v_tick_q;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    localparam logic [SEL_W-1:0] c_idx = SEL_W'(i);

    jump_state_t        r_state, w_state_nxt;
    logic [POS_W-1:0]   r_x, w_x_nxt;
    logic [POS_W-1:0]   r_h, w_h_nxt;
    logic [POS_W:0]     w_x_sum, w_h_sum;
    logic               w_sel;

    assign w_sel   = (i_sel == c_idx);
    // One extra bit so the saturation compare never sees a wrapped sum
    assign w_x_sum = {1'b0, r_x} + {1'b0, c_step};
    assign w_h_sum = {1'b0, r_h} + {1'b0, c_jstep};

    // Next horizontal position: step, wall saturation, then gate clamp
    always_comb begin
      w_x_nxt = r_x;
      if (w_sel && i_m_right && !i_m_left) begin
        w_x_nxt = (w_x_sum > {1'b0, c_x_max}) ? c_x_max : w_x_sum[POS_W-1:0];
        // Only a player approaching from outside the gate is stopped at its edge
        if (!i_gate_open && (r_x <= c_gate_min) && (w_x_nxt > c_gate_min))
          w_x_nxt = c_gate_min;
      end else if (w_sel && i_m_left && !i_m_right) begin
        w_x_nxt = (r_x > c_step) ? (r_x - c_step) : '0;
        if (!i_gate_open && (r_x >= c_gate_max) && (w_x_nxt < c_gate_max))
          w_x_nxt = c_gate_max;
      end
    end

    // Jump FSM next-state and height; m_jump only matters while grounded
    always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      case (r_state)
        ST_GROUND: begin
          if (w_sel && i_m_jump) w_state_nxt = ST_RISE;
        end
        ST_RISE: begin
          if (w_h_sum >= {1'b0, c_jh}) begin
            w_h_nxt     = c_jh;
            w_state_nxt = ST_FALL;
          end else begin
            w_h_nxt = w_h_sum[POS_W-1:0];
          end
        end
        ST_FALL: begin
          if (r_h <= c_jstep) begin
            w_h_nxt     = '0;
            w_state_nxt = ST_GROUND;
          end else begin
            w_h_nxt = r_h - c_jstep;
          end
        end
        default: begin
          w_h_nxt     = '0;
          w_state_nxt = ST_GROUND;
        end
      endcase
    end

    // Player state registers, advanced only on frame cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x     <= c_x_start;
        r_h     <= '0;
        r_state <= ST_GROUND;
      end else if (w_frame) begin
        r_x     <= w_x_nxt;
        r_h     <= w_h_nxt;
        r_state <= w_state_nxt;
      end
    end

    assign o_xpos[i*POS_W +: POS_W] = r_x;
    assign o_ypos[i*POS_W +: POS_W] = c_y_ground - r_h;
    assign o_jumping[i]             = (r_state != ST_GROUND);
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_player_move_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_player_move_ctl
// Description : Self-checking bench for multi_player_move_ctl using a
//               frame-level reference model (jump as an age counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_player_move_ctl;

  localparam int NP    = 2;
  localparam int PW    = 12;
  localparam int XMAX  = 660;
  localparam int GMIN  = 310;
  localparam int GMAX  = 450;
  localparam int STEP  = 4;
  localparam int YG    = 500;
  localparam int JH    = 64;
  localparam int JS    = 4;
  localparam int RISE_F = (JH + JS - 1) / JS;
  localparam int FALL_F = (JH + JS - 1) / JS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v_tick = 1'b0;
  logic          m_left = 1'b0, m_right = 1'b0, m_jump = 1'b0;
  logic [1:0]    sel = '0;
  logic          gate_open = 1'b0;
  logic [NP*PW-1:0] xpos, ypos;
  logic [NP-1:0]    jumping;

  multi_player_move_ctl #(
    .NUM_PLAYERS(NP), .POS_W(PW), .X_START(0), .X_MAX(XMAX),
    .GATE_MIN(GMIN), .GATE_MAX(GMAX), .STEP(STEP), .Y_GROUND(YG),
    .JUMP_HEIGHT(JH), .JUMP_STEP(JS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_v_tick(v_tick), .i_m_left(m_left),
    .i_m_right(m_right), .i_m_jump(m_jump), .i_sel(sel),
    .i_gate_open(gate_open), .o_xpos(xpos), .o_ypos(ypos),
    .o_jumping(jumping)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int mx[NP];
  int mage[NP];   // -1 = on ground, else frames since jump start

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int height(input int age);
    int h;
    if (age < 0) return 0;
    if (age <= RISE_F) begin
      h = age * JS;
      return (h > JH) ? JH : h;
    end
    h = JH - (age - RISE_F) * JS;
    return (h < 0) ? 0 : h;
  endfunction

  function automatic int dut_x(input int i);
    return int'(xpos[i*PW +: PW]);
  endfunction

  function automatic int dut_y(input int i);
    return int'(ypos[i*PW +: PW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i]   = 0;
      mage[i] = -1;
    end
  endtask

  task automatic model_frame();
    int x, xt;
    for (int i = 0; i < NP; i++) begin
      x  = mx[i];
      xt = x;
      if (int'(sel) == i && m_right && !m_left) begin
        xt = (x + STEP > XMAX) ? XMAX : x + STEP;
        if (!gate_open && x <= GMIN && xt > GMIN) xt = GMIN;
      end else if (int'(sel) == i && m_left && !m_right) begin
        xt = (x - STEP < 0) ? 0 : x - STEP;
        if (!gate_open && x >= GMAX && xt < GMAX) xt = GMAX;
      end
      mx[i] = xt;
      if (mage[i] >= 0) begin
        mage[i]++;
        if (mage[i] >= RISE_F + FALL_F) mage[i] = -1;
      end else if (int'(sel) == i && m_jump) begin
        mage[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NP; i++) begin
      check({tag, "_x"},   dut_x(i),        mx[i]);
      check({tag, "_y"},   dut_y(i),        YG - height(mage[i]));
      check({tag, "_jmp"}, int'(jumping[i]), (mage[i] >= 0) ? 1 : 0);
    end
  endtask

  // One frame: inputs applied with a v_tick rising edge, checked next cycle,
  // then a few idle cycles with junk inputs during which nothing may move.
  task automatic do_frame(input logic l, input logic r, input logic j,
                          input logic [1:0] s, input logic g);
    int idle;
    @(negedge clk);
    m_left = l; m_right = r; m_jump = j; sel = s; gate_open = g;
    v_tick = 1'b1;
    model_frame();
    @(negedge clk);
    v_tick = 1'b0;
    check_all("frame");
    idle = $urandom_range(0, 2);
    for (int k = 0; k < idle; k++) begin
      @(negedge clk);
      m_left = 1'($urandom); m_right = 1'($urandom); m_jump = 1'($urandom);
      sel = 2'($urandom);
      check_all("hold");
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v_tick = ~v_tick; m_right = 1'b1; sel = 2'd0; gate_open = 1'b1;
    end
    @(negedge clk);
    check_all("rst_hold");
    v_tick = 1'b0; m_right = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Gate closed: walk right until stopped at the gate edge
    for (int k = 0; k < 90; k++) do_frame(0, 1, 0, 2'd0, 0);
    check("gate_stop", dut_x(0), GMIN);
    do_frame(0, 1, 0, 2'd0, 0);
    check("gate_stop2", dut_x(0), GMIN);
    do_frame(1, 0, 0, 2'd0, 0);
    do_frame(1, 0, 0, 2'd0, 0);
    check("back_left", dut_x(0), 302);
    do_frame(0, 1, 0, 2'd0, 0);
    check("approach1", dut_x(0), 306);
    do_frame(0, 1, 0, 2'd0, 0);
    check("approach2", dut_x(0), 310);
    do_frame(0, 1, 0, 2'd0, 0);
    check("approach3", dut_x(0), 310);
    do_frame(0, 1, 0, 2'd0, 1);
    check("gate_open", dut_x(0), 314);

    // Inside the gate region with gate closed: free to move back out left
    for (int k = 0; k < 78; k++) do_frame(1, 0, 0, 2'd0, 0);
    check("near_wall", dut_x(0), 2);
    do_frame(1, 0, 0, 2'd0, 0);
    check("left_wall", dut_x(0), 0);
    do_frame(1, 0, 0, 2'd0, 0);
    check("left_wall2", dut_x(0), 0);
    check("p1_untouched", dut_x(1), 0);

    // Jump of player 0
    do_frame(0, 0, 1, 2'd0, 0);
    check("jump_start", int'(jumping[0]), 1);
    check("jump_y0", dut_y(0), 500);
    do_frame(0, 0, 0, 2'd0, 0);
    check("jump_y1", dut_y(0), 496);
    for (int k = 0; k < 15; k++) do_frame(0, 0, 0, 2'd0, 0);
    check("jump_peak", dut_y(0), 436);
    for (int k = 0; k < 16; k++) do_frame(0, 0, 0, 2'd0, 0);
    check("jump_land", dut_y(0), 500);
    check("jump_done", int'(jumping[0]), 0);

    // Both directions pressed: no horizontal motion
    do_frame(0, 1, 0, 2'd1, 1);
    do_frame(0, 1, 0, 2'd1, 1);
    do_frame(1, 1, 0, 2'd1, 1);
    check("both_held", dut_x(1), 8);

    // Player 0 jumps, selection moves to player 1 mid-jump
    do_frame(0, 0, 1, 2'd0, 1);
    for (int k = 0; k < 5; k++) do_frame(0, 1, 1, 2'd0, 1);
    do_frame(0, 0, 1, 2'd1, 1);
    check("p1_jump", int'(jumping[1]), 1);
    for (int k = 0; k < 40; k++) do_frame(0, 1, 0, 2'd1, 1);
    check("p0_landed", int'(jumping[0]), 0);

    // Out-of-range selection: nobody moves or starts a jump
    for (int k = 0; k < 10; k++)
      do_frame(1'($urandom), 1'($urandom), 1, 2'd3, 1'($urandom));
    check("sel3_p0", int'(jumping[0]), 0);

    // Right screen limit
    for (int k = 0; k < 170; k++) do_frame(0, 1, 0, 2'd1, 1);
    check("right_wall", dut_x(1), XMAX);

    // v_tick held high: a single update only
    @(negedge clk);
    m_right = 1'b0; m_left = 1'b1; sel = 2'd1; gate_open = 1'b1; m_jump = 1'b0;
    v_tick = 1'b1;
    model_frame();
    for (int k = 0; k < 100; k++) @(negedge clk);
    check_all("held_high");
    check("held_high_x", dut_x(1), XMAX - STEP);
    v_tick = 1'b0;

    // Random traffic
    for (int k = 0; k < 300; k++)
      do_frame(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               2'($urandom), 1'($urandom));

    // Reset aborts a jump in progress
    do_frame(0, 0, 1, 2'd0, 1);
    do_frame(0, 1, 0, 2'd0, 1);
    apply_reset();
    do_frame(0, 0, 0, 2'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
